// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins conflicts unless fetch has been starved STARVE times; reads are tracked back to their issuer.
module mem_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout,
  output logic        stall
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  logic              [3:0] starve_cnt;
  logic                    fetch_prio;
  logic                    d_is_read;
  logic                    rd_issue;
  src_e                    rd_src;
  logic [RD_LAT-1:0]       trk_valid;
  src_e                    trk_src [RD_LAT];

  assign fetch_prio = (starve_cnt == STARVE_MAX);
  assign d_is_read  = (d_we == 4'b0000);

  // Reset gates every combinational output so a held request cannot leak through while rst is low.
  assign i_gnt = rst & i_req & (~d_req | fetch_prio);
  assign d_gnt = rst & d_req & ~(i_req & fetch_prio);
  assign stall = rst & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    m_addr   = 32'h0;
    m_re     = 1'b0;
    m_we     = 4'b0000;
    m_din    = 32'h0;
    rd_issue = 1'b0;
    rd_src   = SRC_FETCH;
    if (i_gnt) begin
      m_addr   = i_addr;
      m_re     = 1'b1;
      rd_issue = 1'b1;
    end else if (d_gnt) begin
      m_addr = d_addr;
      rd_src = SRC_DATA;
      if (d_is_read) begin
        m_re     = 1'b1;
        rd_issue = 1'b1;
      end else begin
        m_we  = d_we;
        m_din = d_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (i_gnt) begin
      starve_cnt <= 4'd0;
    end else if (i_req && (starve_cnt < STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Return tracker: stage 0 takes the read issued this cycle, the last stage lines up with m_dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_valid <= '0;
      for (int k = 0; k < RD_LAT; k++) trk_src[k] <= SRC_FETCH;
    end else begin
      trk_valid[0] <= rd_issue;
      trk_src[0]   <= rd_src;
      for (int k = 1; k < RD_LAT; k++) begin
        trk_valid[k] <= trk_valid[k-1];
        trk_src[k]   <= trk_src[k-1];
      end
    end
  end

  assign i_rvalid = trk_valid[RD_LAT-1] & (trk_src[RD_LAT-1] == SRC_FETCH);
  assign d_rvalid = trk_valid[RD_LAT-1] & (trk_src[RD_LAT-1] == SRC_DATA);
  assign i_rdata  = m_dout;
  assign d_rdata  = m_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=2 and one at RD_LAT=3, sharing stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] m_dout;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_re, stall;
  logic [31:0] i_rdata, d_rdata, m_addr, m_din;
  logic [3:0]  m_we;

  logic        l3_i_gnt, l3_i_rvalid, l3_d_gnt, l3_d_rvalid, l3_m_re, l3_stall;
  logic [31:0] l3_i_rdata, l3_d_rdata, l3_m_addr, l3_m_din;
  logic [3:0]  l3_m_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LAT(2), .STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_din(m_din), .m_dout(m_dout),
    .stall(stall)
  );

  mem_port_arbiter #(.RD_LAT(3), .STARVE(4)) dut_l3 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(l3_i_gnt), .i_rvalid(l3_i_rvalid), .i_rdata(l3_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .m_addr(l3_m_addr), .m_re(l3_m_re), .m_we(l3_m_we), .m_din(l3_m_din), .m_dout(m_dout),
    .stall(l3_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: inputs change 1ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h4000_0000;
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h1000_0000; d_wdata = 32'h0; m_dout = 32'h0;

    // Reset hold with both requests asserted
    next_cycle(); next_cycle(); #2;
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_m_re", 32'(m_re), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_din", m_din, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);

    // Release: data wins in the same cycle (counter is 0), becomes 1 afterwards
    next_cycle(); rst = 1'b1; #2;
    check("rel_d_gnt", 32'(d_gnt), 32'd1);
    check("rel_i_gnt", 32'(i_gnt), 32'd0);
    check("rel_stall", 32'(stall), 32'd1);
    check("rel_m_addr", m_addr, 32'h1000_0000);
    check("rel_m_re", 32'(m_re), 32'd1);

    // Idle cycle
    next_cycle(); i_req = 1'b0; d_req = 1'b0; #2;
    check("idle_m_addr", m_addr, 32'h0);
    check("idle_m_re", 32'(m_re), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    next_cycle(); m_dout = 32'hDEAD_0001; #2;
    check("rel_ret_d_rvalid", 32'(d_rvalid), 32'd1);
    check("rel_ret_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rel_ret_d_rdata", d_rdata, 32'hDEAD_0001);

    // Single fetch, returns two cycles later
    next_cycle(); i_req = 1'b1; i_addr = 32'h4000_0010; #2;
    check("sf_i_gnt", 32'(i_gnt), 32'd1);
    check("sf_m_re", 32'(m_re), 32'd1);
    check("sf_m_addr", m_addr, 32'h4000_0010);
    next_cycle(); i_req = 1'b0; #2;
    check("sf_gap_i_rvalid", 32'(i_rvalid), 32'd0);
    next_cycle(); m_dout = 32'h0000_0013; #2;
    check("sf_i_rvalid", 32'(i_rvalid), 32'd1);
    check("sf_i_rdata", i_rdata, 32'h0000_0013);
    check("sf_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle(); #2;
    check("sf_after_i_rvalid", 32'(i_rvalid), 32'd0);

    // Conflict: data read first, fetch next cycle; returns in issue order
    next_cycle(); i_req = 1'b1; i_addr = 32'h4000_0020; d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h1000_0004; #2;
    check("cf_d_gnt", 32'(d_gnt), 32'd1);
    check("cf_i_gnt", 32'(i_gnt), 32'd0);
    check("cf_stall", 32'(stall), 32'd1);
    check("cf_m_addr", m_addr, 32'h1000_0004);
    next_cycle(); d_req = 1'b0; #2;
    check("cf2_i_gnt", 32'(i_gnt), 32'd1);
    check("cf2_stall", 32'(stall), 32'd0);
    check("cf2_m_addr", m_addr, 32'h4000_0020);
    next_cycle(); i_req = 1'b0; #2;
    check("cf_ret1_d_rvalid", 32'(d_rvalid), 32'd1);
    check("cf_ret1_i_rvalid", 32'(i_rvalid), 32'd0);
    next_cycle(); #2;
    check("cf_ret2_i_rvalid", 32'(i_rvalid), 32'd1);
    check("cf_ret2_d_rvalid", 32'(d_rvalid), 32'd0);

    // Starvation: continuous data writes, fetch held; counter starts at 0
    next_cycle(); i_req = 1'b1; i_addr = 32'h4000_0030;
    d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h1000_0100; d_wdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("sv_c%0d_i_gnt", c), 32'(i_gnt), 32'd0);
      check($sformatf("sv_c%0d_d_gnt", c), 32'(d_gnt), 32'd1);
      next_cycle();
    end
    #2;
    check("sv_c4_i_gnt", 32'(i_gnt), 32'd1);
    check("sv_c4_d_gnt", 32'(d_gnt), 32'd0);
    check("sv_c4_stall", 32'(stall), 32'd1);
    check("sv_c4_m_addr", m_addr, 32'h4000_0030);
    check("sv_c4_m_we", 32'(m_we), 32'd0);
    next_cycle(); #2;
    check("sv_c5_d_gnt", 32'(d_gnt), 32'd1);
    check("sv_c5_i_gnt", 32'(i_gnt), 32'd0);
    check("sv_c5_m_we", 32'(m_we), 32'hF);

    // Write: no read strobe, no rvalid later; the cycle-4 fetch returns meanwhile
    next_cycle(); i_req = 1'b0; d_we = 4'b0100; d_wdata = 32'h00AB_0000; d_addr = 32'h1000_0008; #2;
    check("wr_m_we", 32'(m_we), 32'h4);
    check("wr_m_re", 32'(m_re), 32'd0);
    check("wr_m_din", m_din, 32'h00AB_0000);
    check("wr_m_addr", m_addr, 32'h1000_0008);
    check("sv_ret_i_rvalid", 32'(i_rvalid), 32'd1);
    next_cycle(); d_req = 1'b0; d_we = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      #2;
      check($sformatf("wr_n%0d_d_rvalid", c), 32'(d_rvalid), 32'd0);
      check($sformatf("wr_n%0d_i_rvalid", c), 32'(i_rvalid), 32'd0);
      next_cycle();
    end

    // Reset mid-flight: fetch in R0, rst low in R1, high again in R2
    i_req = 1'b1; i_addr = 32'h4000_0040; #2;
    check("rm_l3_i_gnt", 32'(l3_i_gnt), 32'd1);
    next_cycle(); i_req = 1'b0; rst = 1'b0; #2;
    check("rm_c1_l3_i_rvalid", 32'(l3_i_rvalid), 32'd0);
    next_cycle(); rst = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      #2;
      check($sformatf("rm_c%0d_l3_i_rvalid", c), 32'(l3_i_rvalid), 32'd0);
      check($sformatf("rm_c%0d_i_rvalid", c), 32'(i_rvalid), 32'd0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
